ins_dispatch: RTL and testbench

- Front-end instruction dispatcher for the training accelerator.
- Accepts a stream of INS_W-bit instruction words. Each word is classified as layer config (CFG), load (RD), save (WR) or barrier (SYNC).
- Holds the current layer type and checks every load/save opcode for legality against the current phase.
- Buffers legal load and save instructions in two independent FWFT queues that feed the DDR read and write engines.

---
 rtl/ins_dispatch.sv | 259 +++++++++++++++++++++++++
 tb/tb_ins_dispatch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_dispatch.sv
// Instruction front-end: classifies CFG/RD/WR/SYNC words, checks load/save
// opcodes against the current layer phase and buffers legal ones in two FWFT queues.

module ins_dispatch_fifo #(
    parameter int W     = 62,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   cnt_r;
    logic          push_s;
    logic          pop_s;

    assign full   = (cnt_r == (AW+1)'(DEPTH));
    assign valid  = (cnt_r != (AW+1)'(0));
    assign push_s = push & ~full;
    assign pop_s  = pop & valid;
    assign dout   = mem_r[rptr_r];
    assign cnt    = cnt_r;

    // Storage array; contents beyond the occupancy window are never observed
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= din;
        end
    end

    // Read/write pointers wrap modulo DEPTH, occupancy tracks push minus pop
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_r <= AW'(0);
            rptr_r <= AW'(0);
            cnt_r  <= (AW+1)'(0);
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + AW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
                2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end
endmodule

module ins_dispatch #(
    parameter int INS_W = 64,
    parameter int OP_W  = 4,
    parameter int LT_W  = 3,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INS_W-1:0]       ins,
    input  logic                   ins_valid,
    output logic                   ins_ready,
    output logic [INS_W-3:0]       rd_ins,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [INS_W-3:0]       wr_ins,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    input  logic                   rd_busy,
    input  logic                   wr_busy,
    output logic [$clog2(DEPTH):0] rd_cnt,
    output logic [$clog2(DEPTH):0] wr_cnt,
    output logic [LT_W-1:0]        layer_type,
    output logic                   sync_done,
    output logic                   err,
    output logic [1:0]             err_code,
    input  logic                   err_clr
);
    localparam logic [1:0]      CLS_CFG  = 2'b00;
    localparam logic [1:0]      CLS_RD   = 2'b01;
    localparam logic [1:0]      CLS_WR   = 2'b10;
    localparam logic [1:0]      CLS_SYNC = 2'b11;
    localparam logic [LT_W-2:0] PH_ZERO  = (LT_W-1)'(0);
    localparam logic [LT_W-2:0] PH_TRAIN = (LT_W-1)'(2);
    localparam logic [LT_W-2:0] PH_BAD   = {(LT_W-1){1'b1}};

    // Load opcode legality for a given phase
    function automatic logic rd_legal(input logic [OP_W-1:0] op, input logic [LT_W-2:0] ph);
        logic ok;
        case (op)
            OP_W'(0), OP_W'(1), OP_W'(6), OP_W'(7): ok = 1'b1;
            OP_W'(2):                               ok = (ph != PH_ZERO);
            OP_W'(4), OP_W'(5):                     ok = (ph == PH_TRAIN);
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Save opcode legality for a given phase
    function automatic logic wr_legal(input logic [OP_W-1:0] op, input logic [LT_W-2:0] ph);
        logic ok;
        case (op)
            OP_W'(0):           ok = (ph != PH_TRAIN);
            OP_W'(2), OP_W'(3): ok = (ph == PH_TRAIN);
            OP_W'(4), OP_W'(5): ok = 1'b1;
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [1:0]       cls_s;
    logic [OP_W-1:0]  op_s;
    logic [LT_W-1:0]  cfg_lt_s;
    logic [INS_W-3:0] entry_s;
    logic [LT_W-2:0]  ph_s;
    logic             legal_s;
    logic             ready_s;
    logic             accept_s;
    logic             barrier_ok_s;
    logic             rd_push_s;
    logic             wr_push_s;
    logic             cfg_acc_s;
    logic             sync_acc_s;
    logic             ill_acc_s;
    logic [1:0]       new_code_s;
    logic             rd_full_s;
    logic             wr_full_s;

    logic [LT_W-1:0]  layer_type_r;
    logic             sync_done_r;
    logic             err_r;
    logic [1:0]       err_code_r;

    assign cls_s    = ins[INS_W-1 -: 2];
    assign op_s     = ins[INS_W-3 -: OP_W];
    assign cfg_lt_s = ins[LT_W-1:0];
    assign entry_s  = ins[INS_W-3:0];
    assign ph_s     = layer_type_r[LT_W-1:1];

    assign barrier_ok_s = ~rd_valid & ~wr_valid & ~rd_busy & ~wr_busy;

    // Word classification and legality against the current phase
    always_comb begin
        legal_s    = 1'b0;
        new_code_s = 2'b11;
        case (cls_s)
            CLS_CFG: begin
                legal_s    = (cfg_lt_s[LT_W-1:1] != PH_BAD);
                new_code_s = 2'b11;
            end
            CLS_RD: begin
                legal_s    = rd_legal(op_s, ph_s);
                new_code_s = 2'b01;
            end
            CLS_WR: begin
                legal_s    = wr_legal(op_s, ph_s);
                new_code_s = 2'b10;
            end
            CLS_SYNC: begin
                legal_s    = 1'b1;
                new_code_s = 2'b11;
            end
            default: begin
                legal_s    = 1'b0;
                new_code_s = 2'b11;
            end
        endcase
    end

    // Acceptance: illegal words are always swallowed; queue words depend on
    // fullness only (never on the pop side); barriers wait for a fully idle back end
    always_comb begin
        ready_s = 1'b0;
        if (!rst) begin
            ready_s = 1'b0;
        end else if (!legal_s) begin
            ready_s = 1'b1;
        end else begin
            case (cls_s)
                CLS_RD:  ready_s = ~rd_full_s;
                CLS_WR:  ready_s = ~wr_full_s;
                default: ready_s = barrier_ok_s;
            endcase
        end
    end

    assign accept_s   = ins_valid & ready_s;
    assign rd_push_s  = accept_s & legal_s & (cls_s == CLS_RD);
    assign wr_push_s  = accept_s & legal_s & (cls_s == CLS_WR);
    assign cfg_acc_s  = accept_s & legal_s & (cls_s == CLS_CFG);
    assign sync_acc_s = accept_s & (cls_s == CLS_SYNC);
    assign ill_acc_s  = accept_s & ~legal_s;
    assign ins_ready  = ready_s;

    ins_dispatch_fifo #(.W(INS_W-2), .DEPTH(DEPTH)) u_rd_q (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_push_s),
        .pop   (rd_ready),
        .din   (entry_s),
        .dout  (rd_ins),
        .valid (rd_valid),
        .full  (rd_full_s),
        .cnt   (rd_cnt)
    );

    ins_dispatch_fifo #(.W(INS_W-2), .DEPTH(DEPTH)) u_wr_q (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_push_s),
        .pop   (wr_ready),
        .din   (entry_s),
        .dout  (wr_ins),
        .valid (wr_valid),
        .full  (wr_full_s),
        .cnt   (wr_cnt)
    );

    // Layer type, barrier completion pulse and sticky error capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            layer_type_r <= LT_W'(0);
            sync_done_r  <= 1'b0;
            err_r        <= 1'b0;
            err_code_r   <= 2'b00;
        end else begin
            if (cfg_acc_s) begin
                layer_type_r <= cfg_lt_s;
            end
            sync_done_r <= sync_acc_s;
            if (ill_acc_s) begin
                err_r <= 1'b1;
                // only the first error since the last clear is kept
                if (!err_r || err_clr) begin
                    err_code_r <= new_code_s;
                end
            end else if (err_clr) begin
                err_r      <= 1'b0;
                err_code_r <= 2'b00;
            end
        end
    end

    assign layer_type = layer_type_r;
    assign sync_done  = sync_done_r;
    assign err        = err_r;
    assign err_code   = err_code_r;
endmodule

// File: tb/tb_ins_dispatch.sv
// Bench for ins_dispatch: directed vector table, hand sequences for the full
// queue and pointer wrap, then random traffic against a queue-based model.

module tb_ins_dispatch;
    localparam int INS_W = 64;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ins;
    logic        ins_valid, ins_ready;
    logic [61:0] rd_ins, wr_ins;
    logic        rd_valid, rd_ready, wr_valid, wr_ready;
    logic        rd_busy, wr_busy;
    logic [3:0]  rd_cnt, wr_cnt;
    logic [2:0]  layer_type;
    logic        sync_done, err, err_clr;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    ins_dispatch #(.INS_W(64), .OP_W(4), .LT_W(3), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .rd_ins(rd_ins), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_ins(wr_ins), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_busy(rd_busy), .wr_busy(wr_busy), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
        .layer_type(layer_type), .sync_done(sync_done), .err(err),
        .err_code(err_code), .err_clr(err_clr)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [61:0] m_rd[$];
    logic [61:0] m_wr[$];
    logic [2:0]  m_lt = 3'd0;
    logic        m_err = 1'b0;
    logic [1:0]  m_code = 2'd0;
    logic        m_sync = 1'b0;
    // bit n set = opcode n allowed, indexed by phase
    logic [15:0] rd_mask [4] = '{16'h00C3, 16'h00C7, 16'h00F7, 16'h00C7};
    logic [15:0] wr_mask [4] = '{16'h0031, 16'h0031, 16'h003C, 16'h0031};

    function automatic logic m_legal(input logic [63:0] w);
        logic [15:0] rm, wm;
        rm = rd_mask[m_lt[2:1]];
        wm = wr_mask[m_lt[2:1]];
        case (w[63:62])
            2'b00:   return w[2:1] != 2'b11;
            2'b01:   return rm[w[61:58]];
            2'b10:   return wm[w[61:58]];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic m_ready();
        if (rst !== 1'b1) return 1'b0;
        if (!m_legal(ins)) return 1'b1;
        case (ins[63:62])
            2'b01:   return m_rd.size() < DEPTH;
            2'b10:   return m_wr.size() < DEPTH;
            default: return m_rd.size() == 0 && m_wr.size() == 0 && !rd_busy && !wr_busy;
        endcase
    endfunction

    // one clock: check ready, advance model at the edge, check registered state
    task automatic tick(output logic rdy_seen);
        logic exp_rdy, acc, lg;
        #1;
        exp_rdy  = m_ready();
        rdy_seen = ins_ready;
        check("ins_ready", 64'(ins_ready), 64'(exp_rdy));
        @(posedge clk);
        if (!rst) begin
            m_rd.delete(); m_wr.delete();
            m_lt = 3'd0; m_err = 1'b0; m_code = 2'd0; m_sync = 1'b0;
        end else begin
            acc    = ins_valid && exp_rdy;
            lg     = m_legal(ins);
            m_sync = acc && ins[63:62] == 2'b11;
            if (rd_ready && m_rd.size() > 0) void'(m_rd.pop_front());
            if (wr_ready && m_wr.size() > 0) void'(m_wr.pop_front());
            if (acc && lg) begin
                case (ins[63:62])
                    2'b00:   m_lt = ins[2:0];
                    2'b01:   m_rd.push_back(ins[61:0]);
                    2'b10:   m_wr.push_back(ins[61:0]);
                    default: ;
                endcase
            end
            if (acc && !lg) begin
                if (!m_err || err_clr)
                    m_code = (ins[63:62] == 2'b01) ? 2'd1 : (ins[63:62] == 2'b10) ? 2'd2 : 2'd3;
                m_err = 1'b1;
            end else if (err_clr) begin
                m_err = 1'b0; m_code = 2'd0;
            end
        end
        #1;
        check("rd_cnt", 64'(rd_cnt), 64'(m_rd.size()));
        check("wr_cnt", 64'(wr_cnt), 64'(m_wr.size()));
        check("rd_valid", 64'(rd_valid), 64'(m_rd.size() > 0));
        check("wr_valid", 64'(wr_valid), 64'(m_wr.size() > 0));
        if (m_rd.size() > 0) check("rd_ins", 64'(rd_ins), 64'(m_rd[0]));
        if (m_wr.size() > 0) check("wr_ins", 64'(wr_ins), 64'(m_wr[0]));
        check("layer_type", 64'(layer_type), 64'(m_lt));
        check("err", 64'(err), 64'(m_err));
        check("err_code", 64'(err_code), 64'(m_code));
        check("sync_done", 64'(sync_done), 64'(m_sync));
        @(negedge clk);
    endtask

    function automatic logic [63:0] mk(input logic [1:0] c, input logic [3:0] op, input logic [57:0] pl);
        return {c, op, pl};
    endfunction

    typedef struct {
        logic [63:0] ins;
        logic v, rr, wr, rb, wb, clr, rstn;
        logic e_rdy;
        int   e_rd, e_wr;
        logic [2:0] e_lt;
        logic e_err;
        logic [1:0] e_code;
        logic e_sync;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [63:0] w, input logic v, rr, wrr, rb, wb, clr, rstn,
                       input logic e_rdy, input int e_rd, e_wr, input logic [2:0] e_lt,
                       input logic e_err, input logic [1:0] e_code, input logic e_sync);
        vec_t t;
        t.ins = w; t.v = v; t.rr = rr; t.wr = wrr; t.rb = rb; t.wb = wb; t.clr = clr; t.rstn = rstn;
        t.e_rdy = e_rdy; t.e_rd = e_rd; t.e_wr = e_wr; t.e_lt = e_lt;
        t.e_err = e_err; t.e_code = e_code; t.e_sync = e_sync;
        tbl.push_back(t);
    endtask

    initial begin
        logic        rs;
        logic [63:0] w;
        logic        hold;

        rst = 1'b0; ins = 64'd0; ins_valid = 1'b0; rd_ready = 1'b0; wr_ready = 1'b0;
        rd_busy = 1'b0; wr_busy = 1'b0; err_clr = 1'b0;

        //  word                      v  rr wr rb wb cl rn | rdy rd wr lt err code sync
        add(mk(2'd1, 4'd0, 58'h01),   1, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0, 0);
        add(mk(2'd1, 4'd0, 58'h11),   1, 0, 0, 0, 0, 0, 1,   1,  1, 0, 0, 0, 0, 0);
        add(mk(2'd1, 4'd0, 58'h22),   1, 0, 0, 0, 0, 0, 1,   1,  2, 0, 0, 0, 0, 0);
        add(mk(2'd1, 4'd0, 58'h33),   1, 0, 0, 0, 0, 0, 1,   1,  3, 0, 0, 0, 0, 0);
        add(mk(2'd1, 4'd0, 58'h44),   0, 1, 0, 0, 0, 0, 1,   1,  2, 0, 0, 0, 0, 0);
        add(mk(2'd1, 4'd0, 58'h44),   0, 1, 0, 0, 0, 0, 1,   1,  1, 0, 0, 0, 0, 0);
        add(mk(2'd1, 4'd0, 58'h44),   0, 1, 0, 0, 0, 0, 1,   1,  0, 0, 0, 0, 0, 0);
        add(mk(2'd1, 4'd4, 58'h55),   1, 0, 0, 0, 0, 0, 1,   1,  0, 0, 0, 1, 1, 0);
        add(mk(2'd2, 4'd2, 58'h66),   1, 0, 0, 0, 0, 0, 1,   1,  0, 0, 0, 1, 1, 0);
        add(mk(2'd1, 4'd0, 58'h00),   0, 0, 0, 0, 0, 1, 1,   1,  0, 0, 0, 0, 0, 0);
        add(mk(2'd2, 4'd0, 58'h77),   1, 0, 0, 0, 0, 0, 1,   1,  0, 1, 0, 0, 0, 0);
        add(mk(2'd2, 4'd0, 58'h88),   1, 0, 0, 0, 0, 0, 1,   1,  0, 2, 0, 0, 0, 0);
        add(mk(2'd0, 4'd0, 58'h04),   1, 0, 1, 0, 0, 0, 1,   0,  0, 1, 0, 0, 0, 0);
        add(mk(2'd0, 4'd0, 58'h04),   1, 0, 1, 0, 0, 0, 1,   0,  0, 0, 0, 0, 0, 0);
        add(mk(2'd0, 4'd0, 58'h04),   1, 0, 0, 1, 0, 0, 1,   0,  0, 0, 0, 0, 0, 0);
        add(mk(2'd0, 4'd0, 58'h04),   1, 0, 0, 0, 0, 0, 1,   1,  0, 0, 4, 0, 0, 0);
        add(mk(2'd1, 4'd4, 58'h99),   1, 0, 0, 0, 0, 0, 1,   1,  1, 0, 4, 0, 0, 0);
        add(mk(2'd1, 4'd0, 58'h00),   0, 1, 0, 0, 0, 0, 1,   1,  0, 0, 4, 0, 0, 0);
        add(mk(2'd3, 4'd0, 58'h00),   1, 0, 0, 0, 0, 0, 1,   1,  0, 0, 4, 0, 0, 1);
        add(mk(2'd1, 4'd0, 58'h00),   0, 0, 0, 0, 0, 0, 1,   1,  0, 0, 4, 0, 0, 0);
        add(mk(2'd0, 4'd0, 58'h07),   1, 0, 0, 0, 0, 0, 1,   1,  0, 0, 4, 1, 3, 0);
        for (int i = 1; i <= 4; i++)
            add(mk(2'd1, 4'd0, 58'(i)), 1, 0, 0, 0, 0, 0, 1, 1, i, 0, 4, 1, 3, 0);
        add(mk(2'd1, 4'd0, 58'h00),   0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            ins = tbl[i].ins; ins_valid = tbl[i].v; rd_ready = tbl[i].rr; wr_ready = tbl[i].wr;
            rd_busy = tbl[i].rb; wr_busy = tbl[i].wb; err_clr = tbl[i].clr; rst = tbl[i].rstn;
            tick(rs);
            check($sformatf("v%0d_ready", i), 64'(rs), 64'(tbl[i].e_rdy));
            check($sformatf("v%0d_rd_cnt", i), 64'(rd_cnt), 64'(tbl[i].e_rd));
            check($sformatf("v%0d_wr_cnt", i), 64'(wr_cnt), 64'(tbl[i].e_wr));
            check($sformatf("v%0d_lt", i), 64'(layer_type), 64'(tbl[i].e_lt));
            check($sformatf("v%0d_err", i), 64'(err), 64'(tbl[i].e_err));
            check($sformatf("v%0d_code", i), 64'(err_code), 64'(tbl[i].e_code));
            check($sformatf("v%0d_sync", i), 64'(sync_done), 64'(tbl[i].e_sync));
        end

        // full queue, no bypass on pop, ordering across pointer wrap
        rst = 1'b1; err_clr = 1'b0; rd_ready = 1'b0; ins_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ins = mk(2'd1, 4'd1, 58'(k)); tick(rs);
        end
        ins_valid = 1'b0; rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick(rs);
        rd_ready = 1'b0; ins_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            ins = mk(2'd1, 4'd0, 58'h100 + 58'(k)); tick(rs);
        end
        check("full_ready", 64'(rs), 64'd0);
        check("full_cnt", 64'(rd_cnt), 64'd8);
        rd_ready = 1'b1; tick(rs);
        check("full_pop_ready", 64'(rs), 64'd0);
        rd_ready = 1'b0; tick(rs);
        check("after_pop_ready", 64'(rs), 64'd1);
        check("after_pop_cnt", 64'(rd_cnt), 64'd8);
        ins_valid = 1'b0; rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w = mk(2'd1, 4'd0, 58'h101 + 58'(k));
            check($sformatf("wrap_order%0d", k), 64'(rd_ins), 64'(w[61:0]));
            tick(rs);
        end
        check("drained_valid", 64'(rd_valid), 64'd0);

        // random traffic against the model
        hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) != 0);
            if (!hold) begin
                ins_valid = ($urandom_range(0, 9) < 7);
                w = {$urandom(), $urandom()};
                w[63:62] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 9) < 7) w[61:58] = 4'($urandom_range(0, 7));
                ins = w;
            end
            rd_ready = ($urandom_range(0, 9) < 3);
            wr_ready = ($urandom_range(0, 9) < 3);
            rd_busy  = ($urandom_range(0, 9) == 0);
            wr_busy  = ($urandom_range(0, 9) == 0);
            err_clr  = ($urandom_range(0, 19) == 0);
            tick(rs);
            hold = ins_valid && !rs;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
